// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, data-enable, sync decode,
// line/frame strobes, frame counter and a ce-qualified delayed copy of
// valid/hsync/vsync for matching downstream pixel-pipeline latency.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PIPE_DLY = 2,
    parameter int   CNT_W    = 11,
    parameter int   FC_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    output logic [CNT_W-1:0] x_pix,
    output logic [CNT_W-1:0] y_pix,
    output logic             valid,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_cnt,
    output logic             valid_d,
    output logic             hsync_d,
    output logic             vsync_d
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] X_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] Y_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Inactive pattern {valid, hsync, vsync} used for reset and pipeline fill
    localparam logic [2:0] IDLE_BITS = {1'b0, ~HS_POL, ~VS_POL};

    logic [CNT_W-1:0] x_reg, y_reg;
    logic [CNT_W-1:0] x_next, y_next;
    logic             valid_reg, hsync_reg, vsync_reg;
    logic             valid_next, hsync_next, vsync_next;
    logic             line_start_reg, frame_start_reg;
    logic [FC_W-1:0]  frame_cnt_reg;

    // Next-state counters and the sync/enable decode of that next position,
    // so registered decode lines up with the registered counters.
    always_comb begin
        x_next = (x_reg == X_LAST) ? '0 : x_reg + CNT_W'(1);
        y_next = y_reg;
        if (x_reg == X_LAST) begin
            y_next = (y_reg == Y_LAST) ? '0 : y_reg + CNT_W'(1);
        end
        valid_next = (x_next < X_ACT) && (y_next < Y_ACT);
        hsync_next = ((x_next >= HS_START) && (x_next < HS_END)) ? HS_POL : ~HS_POL;
        vsync_next = ((y_next >= VS_START) && (y_next < VS_END)) ? VS_POL : ~VS_POL;
    end

    // Counter, decode and strobe registers; reset parks at the last pixel so
    // the first ce lands on (0,0) and starts frame 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg           <= X_LAST;
            y_reg           <= Y_LAST;
            valid_reg       <= 1'b0;
            hsync_reg       <= ~HS_POL;
            vsync_reg       <= ~VS_POL;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_cnt_reg   <= '0;
        end else if (ce) begin
            x_reg           <= x_next;
            y_reg           <= y_next;
            valid_reg       <= valid_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            line_start_reg  <= (x_next == '0);
            frame_start_reg <= (x_next == '0) && (y_next == '0);
            if ((x_next == '0) && (y_next == '0)) begin
                frame_cnt_reg <= frame_cnt_reg + FC_W'(1);
            end
        end else begin
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end
    end

    assign x_pix       = x_reg;
    assign y_pix       = y_reg;
    assign valid       = valid_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign frame_cnt   = frame_cnt_reg;

    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign {valid_d, hsync_d, vsync_d} = {valid_reg, hsync_reg, vsync_reg};
        end else begin : g_dly
            logic [2:0] dly_reg [PIPE_DLY];
            for (genvar gi = 0; gi < PIPE_DLY; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    // First stage samples the current registered decode
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            dly_reg[gi] <= IDLE_BITS;
                        end else if (ce) begin
                            dly_reg[gi] <= {valid_reg, hsync_reg, vsync_reg};
                        end
                    end
                end else begin : g_next
                    // Later stages shift by one pixel per ce
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            dly_reg[gi] <= IDLE_BITS;
                        end else if (ce) begin
                            dly_reg[gi] <= dly_reg[gi-1];
                        end
                    end
                end
            end
            assign {valid_d, hsync_d, vsync_d} = dly_reg[PIPE_DLY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default VGA mode, a small mode with
// positive syncs and 2-bit frame counter, and the small mode with no delay.
// Expected values come from a position model: after k ce-pixels since reset
// the raster position is (k-1) mod frame_size.
module tb_vga_timing_gen;

    typedef struct {
        int   ha, hf, hs, hb, va, vf, vs, vb;
        logic hp, vp;
    } mode_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b0;

    logic [10:0] x_def, y_def;
    logic        valid_def, hs_def, vs_def, ls_def, fs_def, vd_def, hd_def, vsd_def;
    logic [7:0]  fc_def;

    logic [3:0]  x_sm, y_sm;
    logic        valid_sm, hs_sm, vs_sm, ls_sm, fs_sm, vd_sm, hd_sm, vsd_sm;
    logic [1:0]  fc_sm;

    logic [3:0]  x_p0, y_p0;
    logic        valid_p0, hs_p0, vs_p0, ls_p0, fs_p0, vd_p0, hd_p0, vsd_p0;
    logic [1:0]  fc_p0;

    int    n_chk  = 0;
    int    n_fail = 0;
    int    n      = 0;     // ce-pixels since reset
    bit    last_ce = 0;    // previous clk was a non-reset ce clk
    mode_t md_def, md_sm;

    always #5 clk = ~clk;

    vga_timing_gen dut_def (
        .clk(clk), .rst(rst), .ce(ce), .x_pix(x_def), .y_pix(y_def), .valid(valid_def),
        .hsync(hs_def), .vsync(vs_def), .line_start(ls_def), .frame_start(fs_def),
        .frame_cnt(fc_def), .valid_d(vd_def), .hsync_d(hd_def), .vsync_d(vsd_def)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
        .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(3), .CNT_W(4), .FC_W(2)
    ) dut_sm (
        .clk(clk), .rst(rst), .ce(ce), .x_pix(x_sm), .y_pix(y_sm), .valid(valid_sm),
        .hsync(hs_sm), .vsync(vs_sm), .line_start(ls_sm), .frame_start(fs_sm),
        .frame_cnt(fc_sm), .valid_d(vd_sm), .hsync_d(hd_sm), .vsync_d(vsd_sm)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
        .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0), .CNT_W(4), .FC_W(2)
    ) dut_p0 (
        .clk(clk), .rst(rst), .ce(ce), .x_pix(x_p0), .y_pix(y_p0), .valid(valid_p0),
        .hsync(hs_p0), .vsync(vs_p0), .line_start(ls_p0), .frame_start(fs_p0),
        .frame_cnt(fc_p0), .valid_d(vd_p0), .hsync_d(hd_p0), .vsync_d(vsd_p0)
    );

    // ---------------- reference model ----------------
    function automatic int m_ht(mode_t m); return m.ha + m.hf + m.hs + m.hb; endfunction
    function automatic int m_vt(mode_t m); return m.va + m.vf + m.vs + m.vb; endfunction

    function automatic int m_x(mode_t m, int k);
        if (k <= 0) return m_ht(m) - 1;
        return ((k - 1) % (m_ht(m) * m_vt(m))) % m_ht(m);
    endfunction

    function automatic int m_y(mode_t m, int k);
        if (k <= 0) return m_vt(m) - 1;
        return ((k - 1) % (m_ht(m) * m_vt(m))) / m_ht(m);
    endfunction

    function automatic logic m_valid(mode_t m, int k);
        if (k <= 0) return 1'b0;
        return (m_x(m, k) < m.ha) && (m_y(m, k) < m.va);
    endfunction

    function automatic logic m_hs(mode_t m, int k);
        int x;
        if (k <= 0) return ~m.hp;
        x = m_x(m, k);
        return (x >= m.ha + m.hf && x < m.ha + m.hf + m.hs) ? m.hp : ~m.hp;
    endfunction

    function automatic logic m_vs(mode_t m, int k);
        int y;
        if (k <= 0) return ~m.vp;
        y = m_y(m, k);
        return (y >= m.va + m.vf && y < m.va + m.vf + m.vs) ? m.vp : ~m.vp;
    endfunction

    function automatic int m_fc(mode_t m, int k, int w);
        if (k <= 0) return 0;
        return (((k - 1) / (m_ht(m) * m_vt(m))) + 1) % (1 << w);
    endfunction

    function automatic logic m_ls(mode_t m);
        return last_ce && (n >= 1) && (m_x(m, n) == 0);
    endfunction

    function automatic logic m_fs(mode_t m);
        return last_ce && (n >= 1) && (m_x(m, n) == 0) && (m_y(m, n) == 0);
    endfunction

    // Drive one clock and advance the model; outputs are sampled 1ns later
    task automatic tick(input logic r, input logic c);
        rst = r;
        ce  = c;
        @(posedge clk);
        if (r) begin
            n = 0;
            last_ce = 0;
        end else begin
            if (c) n++;
            last_ce = c;
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 1'($urandom_range(0, 1)));
        n_chk++; if (x_def !== 11'd799) begin n_fail++; $display("FAIL reset_x_def got=%0d exp=799", x_def); end
        n_chk++; if (y_def !== 11'd524) begin n_fail++; $display("FAIL reset_y_def got=%0d exp=524", y_def); end
        n_chk++; if ({valid_def, hs_def, vs_def} !== 3'b011) begin n_fail++; $display("FAIL reset_vhv_def got=%b exp=011", {valid_def, hs_def, vs_def}); end
        n_chk++; if ({ls_def, fs_def} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses_def got=%b exp=00", {ls_def, fs_def}); end
        n_chk++; if (fc_def !== 8'd0) begin n_fail++; $display("FAIL reset_fc_def got=%0d exp=0", fc_def); end
        n_chk++; if ({vd_def, hd_def, vsd_def} !== 3'b011) begin n_fail++; $display("FAIL reset_dly_def got=%b exp=011", {vd_def, hd_def, vsd_def}); end
        n_chk++; if ({x_sm, y_sm} !== {4'd14, 4'd6}) begin n_fail++; $display("FAIL reset_xy_sm got=%0d,%0d exp=14,6", x_sm, y_sm); end
        n_chk++; if ({valid_sm, hs_sm, vs_sm, vd_sm, hd_sm, vsd_sm} !== 6'b000000) begin n_fail++; $display("FAIL reset_sync_sm got=%b exp=000000", {valid_sm, hs_sm, vs_sm, vd_sm, hd_sm, vsd_sm}); end
    endtask

    task automatic test_first_ce();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        n_chk++; if (x_def !== 11'd799 || ls_def !== 1'b0) begin n_fail++; $display("FAIL hold_before_ce got x=%0d ls=%b exp x=799 ls=0", x_def, ls_def); end
        tick(1'b0, 1'b1);
        n_chk++; if ({x_def, y_def} !== 22'd0) begin n_fail++; $display("FAIL first_xy got=%0d,%0d exp=0,0", x_def, y_def); end
        n_chk++; if ({fs_def, ls_def} !== 2'b11) begin n_fail++; $display("FAIL first_pulses got=%b exp=11", {fs_def, ls_def}); end
        n_chk++; if (fc_def !== 8'd1) begin n_fail++; $display("FAIL first_fc got=%0d exp=1", fc_def); end
        n_chk++; if (valid_def !== 1'b1) begin n_fail++; $display("FAIL first_valid got=%b exp=1", valid_def); end
    endtask

    task automatic test_hsync_line();
        int lows = 0, min_x = 9999, max_x = -1, last_ls = -1, gap = 0;
        for (int i = 0; i < 1600; i++) begin
            tick(1'b0, 1'b1);
            n_chk++; if (x_def !== 11'(m_x(md_def, n)) || hs_def !== m_hs(md_def, n) || valid_def !== m_valid(md_def, n))
                begin n_fail++; $display("FAIL line_decode n=%0d got x=%0d hs=%b v=%b exp x=%0d hs=%b v=%b", n, x_def, hs_def, valid_def, m_x(md_def, n), m_hs(md_def, n), m_valid(md_def, n)); end
            if (y_def == 11'd1 && hs_def == 1'b0) begin
                lows++;
                if (int'(x_def) < min_x) min_x = int'(x_def);
                if (int'(x_def) > max_x) max_x = int'(x_def);
            end
            if (ls_def === 1'b1) begin
                if (last_ls >= 0) gap = i - last_ls;
                last_ls = i;
            end
        end
        n_chk++; if (lows != 96) begin n_fail++; $display("FAIL hsync_width got=%0d exp=96", lows); end
        n_chk++; if (min_x != 656 || max_x != 751) begin n_fail++; $display("FAIL hsync_range got=%0d..%0d exp=656..751", min_x, max_x); end
        n_chk++; if (gap != 800) begin n_fail++; $display("FAIL line_period got=%0d exp=800", gap); end
    endtask

    task automatic test_ce_toggle();
        int last_ls = -1, gap = 0;
        for (int i = 0; i < 3200; i++) begin
            tick(1'b0, 1'(i % 2 == 0));
            n_chk++; if (x_def !== 11'(m_x(md_def, n)) || y_def !== 11'(m_y(md_def, n)) || ls_def !== m_ls(md_def))
                begin n_fail++; $display("FAIL toggle_state i=%0d got x=%0d y=%0d ls=%b exp x=%0d y=%0d ls=%b", i, x_def, y_def, ls_def, m_x(md_def, n), m_y(md_def, n), m_ls(md_def)); end
            if (!ce) begin
                n_chk++; if ({ls_def, fs_def, ls_sm, fs_sm} !== 4'b0000) begin n_fail++; $display("FAIL toggle_pulse_on_idle i=%0d got=%b exp=0000", i, {ls_def, fs_def, ls_sm, fs_sm}); end
            end
            if (ls_def === 1'b1) begin
                if (last_ls >= 0) gap = i - last_ls;
                last_ls = i;
            end
        end
        n_chk++; if (gap != 1600) begin n_fail++; $display("FAIL toggle_line_period got=%0d exp=1600", gap); end
    endtask

    task automatic test_random_ce();
        for (int i = 0; i < 3000; i++) begin
            tick(1'b0, 1'($urandom_range(0, 3) != 0));
            n_chk++; if ({x_def, y_def} !== {11'(m_x(md_def, n)), 11'(m_y(md_def, n))} || fc_def !== 8'(m_fc(md_def, n, 8)))
                begin n_fail++; $display("FAIL rnd_pos_def n=%0d got %0d,%0d fc=%0d exp %0d,%0d fc=%0d", n, x_def, y_def, fc_def, m_x(md_def, n), m_y(md_def, n), m_fc(md_def, n, 8)); end
            n_chk++; if ({valid_def, hs_def, vs_def, ls_def, fs_def} !== {m_valid(md_def, n), m_hs(md_def, n), m_vs(md_def, n), m_ls(md_def), m_fs(md_def)})
                begin n_fail++; $display("FAIL rnd_flags_def n=%0d got=%b exp=%b", n, {valid_def, hs_def, vs_def, ls_def, fs_def}, {m_valid(md_def, n), m_hs(md_def, n), m_vs(md_def, n), m_ls(md_def), m_fs(md_def)}); end
            n_chk++; if ({x_sm, y_sm, fc_sm} !== {4'(m_x(md_sm, n)), 4'(m_y(md_sm, n)), 2'(m_fc(md_sm, n, 2))})
                begin n_fail++; $display("FAIL rnd_pos_sm n=%0d got %0d,%0d fc=%0d exp %0d,%0d fc=%0d", n, x_sm, y_sm, fc_sm, m_x(md_sm, n), m_y(md_sm, n), m_fc(md_sm, n, 2)); end
            n_chk++; if ({valid_sm, hs_sm, vs_sm, ls_sm, fs_sm} !== {m_valid(md_sm, n), m_hs(md_sm, n), m_vs(md_sm, n), m_ls(md_sm), m_fs(md_sm)})
                begin n_fail++; $display("FAIL rnd_flags_sm n=%0d got=%b exp=%b", n, {valid_sm, hs_sm, vs_sm, ls_sm, fs_sm}, {m_valid(md_sm, n), m_hs(md_sm, n), m_vs(md_sm, n), m_ls(md_sm), m_fs(md_sm)}); end
        end
    endtask

    task automatic test_small_frames();
        int wraps = 0, hs_lo = 99, hs_hi = -1, vs_lines = 0;
        logic [1:0] prev_fc;
        prev_fc = fc_sm;
        for (int i = 0; i < 6 * 105; i++) begin
            tick(1'b0, 1'b1);
            n_chk++; if ({hs_sm, vs_sm, valid_sm, fs_sm, fc_sm} !== {m_hs(md_sm, n), m_vs(md_sm, n), m_valid(md_sm, n), m_fs(md_sm), 2'(m_fc(md_sm, n, 2))})
                begin n_fail++; $display("FAIL small_frame n=%0d got=%b exp=%b", n, {hs_sm, vs_sm, valid_sm, fs_sm, fc_sm}, {m_hs(md_sm, n), m_vs(md_sm, n), m_valid(md_sm, n), m_fs(md_sm), 2'(m_fc(md_sm, n, 2))}); end
            if (prev_fc == 2'd3 && fc_sm == 2'd0 && fs_sm == 1'b1) wraps++;
            if (hs_sm == 1'b1 && y_sm == 4'd0) begin
                if (int'(x_sm) < hs_lo) hs_lo = int'(x_sm);
                if (int'(x_sm) > hs_hi) hs_hi = int'(x_sm);
            end
            if (vs_sm == 1'b1 && x_sm == 4'd0) vs_lines++;
            prev_fc = fc_sm;
        end
        n_chk++; if (wraps == 0) begin n_fail++; $display("FAIL small_fc_wrap got=%0d exp>=1", wraps); end
        n_chk++; if (hs_lo != 10 || hs_hi != 12) begin n_fail++; $display("FAIL small_hsync_range got=%0d..%0d exp=10..12", hs_lo, hs_hi); end
        n_chk++; if (vs_lines != 6) begin n_fail++; $display("FAIL small_vsync_lines got=%0d exp=6", vs_lines); end
    endtask

    task automatic test_pipe_delay();
        for (int i = 0; i < 800; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)));
            n_chk++; if ({vd_def, hd_def, vsd_def} !== {m_valid(md_def, n - 2), m_hs(md_def, n - 2), m_vs(md_def, n - 2)})
                begin n_fail++; $display("FAIL dly_def n=%0d got=%b exp=%b", n, {vd_def, hd_def, vsd_def}, {m_valid(md_def, n - 2), m_hs(md_def, n - 2), m_vs(md_def, n - 2)}); end
            n_chk++; if ({vd_sm, hd_sm, vsd_sm} !== {m_valid(md_sm, n - 3), m_hs(md_sm, n - 3), m_vs(md_sm, n - 3)})
                begin n_fail++; $display("FAIL dly_sm n=%0d got=%b exp=%b", n, {vd_sm, hd_sm, vsd_sm}, {m_valid(md_sm, n - 3), m_hs(md_sm, n - 3), m_vs(md_sm, n - 3)}); end
            n_chk++; if ({vd_p0, hd_p0, vsd_p0} !== {m_valid(md_sm, n), m_hs(md_sm, n), m_vs(md_sm, n)})
                begin n_fail++; $display("FAIL dly_zero n=%0d got=%b exp=%b", n, {vd_p0, hd_p0, vsd_p0}, {m_valid(md_sm, n), m_hs(md_sm, n), m_vs(md_sm, n)}); end
        end
    endtask

    task automatic test_mid_reset();
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(1'b0, 1'b1);
            if (m_y(md_sm, n) == 3 && m_x(md_sm, n) == 4) found = 1;
        end
        n_chk++; if (!found || x_sm !== 4'd4 || y_sm !== 4'd3) begin n_fail++; $display("FAIL midrst_reach got=%0d,%0d exp=4,3", x_sm, y_sm); end
        tick(1'b1, 1'b0);
        n_chk++; if ({x_sm, y_sm, fc_sm} !== {4'd14, 4'd6, 2'd0}) begin n_fail++; $display("FAIL midrst_sm got %0d,%0d fc=%0d exp 14,6 fc=0", x_sm, y_sm, fc_sm); end
        n_chk++; if ({valid_sm, hs_sm, vs_sm, ls_sm, fs_sm, vd_sm, hd_sm, vsd_sm} !== 8'b0) begin n_fail++; $display("FAIL midrst_flags_sm got=%b exp=00000000", {valid_sm, hs_sm, vs_sm, ls_sm, fs_sm, vd_sm, hd_sm, vsd_sm}); end
        n_chk++; if ({x_def, y_def, fc_def} !== {11'd799, 11'd524, 8'd0}) begin n_fail++; $display("FAIL midrst_def got %0d,%0d fc=%0d exp 799,524 fc=0", x_def, y_def, fc_def); end
        tick(1'b0, 1'b1);
        n_chk++; if ({x_sm, y_sm, fs_sm, fc_sm} !== {4'd0, 4'd0, 1'b1, 2'd1}) begin n_fail++; $display("FAIL midrst_restart got %0d,%0d fs=%b fc=%0d exp 0,0 fs=1 fc=1", x_sm, y_sm, fs_sm, fc_sm); end
    endtask

    initial begin
        md_def = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        md_sm  = '{8, 2, 3, 2, 4, 1, 1, 1, 1'b1, 1'b1};
        test_reset();
        test_first_ce();
        test_hsync_line();
        test_ce_toggle();
        test_random_ce();
        test_small_frames();
        test_pipe_delay();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
